// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   localparam int unsigned DIV_N = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step_module.sv
// One combinational restoring-division step built on a ripple borrow chain.
module div_step_module #(
   parameter int unsigned N = 4
) (
   input  logic [N:0]   partial_i,
   input  logic [N-1:0] divisor_i,
   output logic [N-1:0] rem_o,
   output logic         q_bit_o
);

   logic [N:0]   subtrahend;
   logic [N:0]   diff;
   logic [N+1:0] borrow;

   assign subtrahend = {1'b0, divisor_i};

   always_comb begin
      borrow    = '0;
      diff      = '0;
      for (int i = 0; i <= N; i++) begin
         diff[i]     = partial_i[i] ^ subtrahend[i] ^ borrow[i];
         borrow[i+1] = (~partial_i[i] & subtrahend[i]) |
                       (~(partial_i[i] ^ subtrahend[i]) & borrow[i]);
      end
   end

   // A kept difference is below the divisor and a restored partial is too,
   // so the top bit is always zero in either case.
   assign q_bit_o = ~borrow[N+1];
   assign rem_o   = q_bit_o ? diff[N-1:0] : partial_i[N-1:0];

endmodule

// File: rtl/seq_divider_module.sv
// Unsigned sequential divider: one restoring step per clock, MSB first.
module seq_divider_module
   import div_pkg::*;
#(
   parameter int unsigned N = DIV_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Q,
   output logic [N-1:0] R,
   output logic         dz
);

   localparam int unsigned     CntW     = $clog2(N + 1);
   localparam logic [CntW-1:0] LastStep = CntW'(N - 1);

   div_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [N-1:0]    rem_q, rem_d;
   logic [N-1:0]    dvd_q, dvd_d;
   logic [N-1:0]    dvs_q, dvs_d;
   logic [N-1:0]    quo_res_q, quo_res_d;
   logic [N-1:0]    rem_res_q, rem_res_d;
   logic            dz_q, dz_d;

   logic [N-1:0]    step_rem;
   logic            step_q_bit;

   div_step_module #(
      .N (N)
   ) u_step (
      .partial_i ({rem_q, dvd_q[N-1]}),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .q_bit_o   (step_q_bit)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      quo_res_d = quo_res_q;
      rem_res_d = rem_res_q;
      dz_d      = dz_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d = A;
               dvs_d = B;
               cnt_d = '0;
               rem_d = '0;
               if (B == '0) begin
                  state_d   = DONE;
                  quo_res_d = '1;
                  rem_res_d = A;
                  dz_d      = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // Dividend bits shift out the top while quotient bits fill the bottom.
            rem_d = step_rem;
            dvd_d = {dvd_q[N-2:0], step_q_bit};
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastStep) begin
               state_d   = DONE;
               quo_res_d = {dvd_q[N-2:0], step_q_bit};
               rem_res_d = step_rem;
               dz_d      = 1'b0;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         quo_res_q <= '0;
         rem_res_q <= '0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         quo_res_q <= quo_res_d;
         rem_res_q <= rem_res_d;
         dz_q      <= dz_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign Q    = quo_res_q;
   assign R    = rem_res_q;
   assign dz   = dz_q;

endmodule

// File: tb/tb_seq_divider_module.sv
// Self-checking bench: directed table, exhaustive sweep and multi-cycle corners.
module tb_seq_divider_module;

   localparam int unsigned N = 4;

   typedef struct packed {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
   } exp_t;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic [N-1:0] Q;
   logic [N-1:0] R;
   logic         dz;

   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;
   int   n_exp  = 0;
   exp_t sb[$];
   vec_t vecs[7];

   seq_divider_module #(
      .N (N)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Q     (Q),
      .R     (R),
      .dz    (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         exp_t e;
         n_done++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'(0));
         end else begin
            e = sb.pop_front();
            chk("Q", 32'(Q), 32'(e.q));
            chk("R", 32'(R), 32'(e.r));
            chk("dz", 32'(dz), 32'(e.dz));
         end
      end
   end

   task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b, input exp_t e);
      int lat = 0;
      int bcnt = 0;
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      sb.push_back(e);
      n_exp++;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = N'($urandom);
      B = N'($urandom);
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy) bcnt++;
         if (done) break;
      end
      if (!done) begin
         chk("timeout", 32'(done), 32'(1));
      end else begin
         chk("latency", 32'(lat), (b == '0) ? 32'(1) : 32'(N + 1));
         chk("busy_cycles", 32'(bcnt), (b == '0) ? 32'(0) : 32'(N));
      end
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'(0));
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (done) break;
      end
      if (!done) chk("timeout", 32'(done), 32'(1));
   endtask

   initial begin
      int lat;
      int d0;
      vecs[0] = '{a: 13, b: 3,  q: 4,  r: 1, dz: 0};
      vecs[1] = '{a: 15, b: 1,  q: 15, r: 0, dz: 0};
      vecs[2] = '{a: 2,  b: 9,  q: 0,  r: 2, dz: 0};
      vecs[3] = '{a: 7,  b: 0,  q: 15, r: 7, dz: 1};
      vecs[4] = '{a: 0,  b: 5,  q: 0,  r: 0, dz: 0};
      vecs[5] = '{a: 15, b: 15, q: 1,  r: 0, dz: 0};
      vecs[6] = '{a: 0,  b: 0,  q: 15, r: 0, dz: 1};

      rst_n = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_Q", 32'(Q), 32'(0));
      chk("rst_R", 32'(R), 32'(0));
      chk("rst_dz", 32'(dz), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         do_div(vecs[i].a, vecs[i].b, '{q: vecs[i].q, r: vecs[i].r, dz: vecs[i].dz});
      end

      // Start and operand changes during RUN are ignored.
      @(negedge clk);
      A = 12;
      B = 5;
      start = 1'b1;
      sb.push_back('{q: 2, r: 2, dz: 0});
      n_exp++;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      A = 3;
      B = 0;
      wait_done(lat);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("midop_done_count", 32'(n_done), 32'(n_exp));

      // Reset in the second RUN cycle aborts with no done.
      @(negedge clk);
      A = 13;
      B = 3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_Q", 32'(Q), 32'(0));
      chk("abort_R", 32'(R), 32'(0));
      chk("abort_dz", 32'(dz), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("abort_no_done", 32'(n_done), 32'(n_exp));
      do_div(9, 4, '{q: 2, r: 1, dz: 0});

      // Start held high: back-to-back with one IDLE cycle between.
      @(negedge clk);
      A = 11;
      B = 2;
      start = 1'b1;
      sb.push_back('{q: 5, r: 1, dz: 0});
      sb.push_back('{q: 5, r: 1, dz: 0});
      n_exp += 2;
      wait_done(lat);
      d0 = n_done;
      wait_done(lat);
      start = 1'b0;
      chk("b2b_gap", 32'(lat), 32'(N + 2));
      chk("b2b_count", 32'(n_done - d0), 32'(1));
      repeat (3) @(negedge clk);

      for (int a = 0; a < 16; a++) begin
         for (int b = 1; b < 16; b++) begin
            do_div(N'(a), N'(b), '{q: N'(a / b), r: N'(a % b), dz: 1'b0});
         end
      end

      repeat (4) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'(0));
      chk("done_total", 32'(n_done), 32'(n_exp));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
